// File: rtl/mac_seq_ctrl.sv
// Weight-address / index sequencer for one fully-connected layer pass.
// Drives the external address counter register and the MAC enable/clear/last strobes.
module mac_seq_ctrl #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_in,
  input  logic [IDX_W-1:0]  n_out,
  input  logic [ADDR_W-1:0] base_w,
  input  logic              stall,
  input  logic [ADDR_W-1:0] cnt_q,
  output logic [ADDR_W-1:0] cnt_d,
  output logic [ADDR_W-1:0] w_addr,
  output logic [IDX_W-1:0]  x_idx,
  output logic [IDX_W-1:0]  n_idx,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              acc_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_x_idx;
  logic [IDX_W-1:0]   r_n_idx;
  logic [IDX_W-1:0]   r_n_in;
  logic [IDX_W-1:0]   r_n_out;
  logic               r_done;
  logic               r_err;

  logic               w_idle;
  logic               w_sizes_ok;
  logic               w_accept;
  logic               w_reject;
  logic               w_step;
  logic               w_first;
  logic               w_last;
  logic               w_last_neuron;

  assign w_idle        = (r_state == S_IDLE);
  assign w_sizes_ok    = (n_in != '0) && (n_out != '0);
  assign w_accept      = w_idle && start && w_sizes_ok;
  assign w_reject      = w_idle && start && !w_sizes_ok;
  assign w_step        = (r_state == S_RUN) && !stall;
  assign w_first       = (r_x_idx == '0);
  assign w_last        = (r_x_idx == (r_n_in - IDX_W'(1)));
  assign w_last_neuron = (r_n_idx == (r_n_out - IDX_W'(1)));

  // This block is the only writer of the counter register; reset forces it to clear.
  always_comb begin
    cnt_d = cnt_q;
    if (!rst_n) begin
      cnt_d = '0;
    end else if (w_accept) begin
      cnt_d = base_w;
    end else if (w_step) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x_idx <= '0;
      r_n_idx <= '0;
      r_n_in  <= '0;
      r_n_out <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err  <= w_reject;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n_in  <= n_in;
            r_n_out <= n_out;
            r_x_idx <= '0;
            r_n_idx <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_step) begin
            if (w_last) begin
              r_x_idx <= '0;
              r_n_idx <= r_n_idx + IDX_W'(1);
              if (w_last_neuron) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_x_idx <= r_x_idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_addr   = cnt_q;
  assign x_idx    = r_x_idx;
  assign n_idx    = r_n_idx;
  assign mac_en   = w_step;
  assign mac_clr  = w_step && w_first;
  assign acc_last = w_step && w_last;
  assign busy     = !w_idle;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl; models the external counter register locally.
module tb_mac_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  n_in;
  logic [7:0]  n_out;
  logic [15:0] base_w;
  logic        stall;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] w_addr;
  logic [7:0]  x_idx;
  logic [7:0]  n_idx;
  logic        mac_en;
  logic        mac_clr;
  logic        acc_last;
  logic        busy;
  logic        done;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  mac_seq_ctrl #(.ADDR_W(16), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .n_out(n_out),
    .base_w(base_w), .stall(stall), .cnt_q(cnt_q), .cnt_d(cnt_d),
    .w_addr(w_addr), .x_idx(x_idx), .n_idx(n_idx), .mac_en(mac_en),
    .mac_clr(mac_clr), .acc_last(acc_last), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cnt_q <= cnt_d;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are looked at 1 ns later, mid-cycle.
  task automatic applyStimulus(input logic st, input logic [7:0] ni, input logic [7:0] no,
                               input logic [15:0] bw, input logic stl);
    @(negedge clk);
    start  = st;
    n_in   = ni;
    n_out  = no;
    base_w = bw;
    stall  = stl;
    #1;
  endtask

  task automatic runBasicPass();
    bit          clrTab[6]  = '{1, 0, 0, 1, 0, 0};
    bit          lastTab[6] = '{0, 0, 1, 0, 0, 1};
    logic [7:0]  nTab[6]    = '{0, 0, 0, 1, 1, 1};
    logic [7:0]  xTab[6]    = '{0, 1, 2, 0, 1, 2};
    applyStimulus(1'b1, 8'd3, 8'd2, 16'h0100, 1'b0);
    checkOutput("basic_accept_cnt_d", cnt_d, 16'h0100);
    checkOutput("basic_accept_busy", busy, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, 1'b0);
      checkOutput($sformatf("basic_waddr_c%0d", k), w_addr, 16'h0100 + 16'(k - 1));
      checkOutput($sformatf("basic_en_c%0d", k), mac_en, 1'b1);
      checkOutput($sformatf("basic_clr_c%0d", k), mac_clr, clrTab[k-1]);
      checkOutput($sformatf("basic_last_c%0d", k), acc_last, lastTab[k-1]);
      checkOutput($sformatf("basic_nidx_c%0d", k), n_idx, nTab[k-1]);
      checkOutput($sformatf("basic_xidx_c%0d", k), x_idx, xTab[k-1]);
      checkOutput($sformatf("basic_done_c%0d", k), done, 1'b0);
    end
    applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, 1'b0);
    checkOutput("basic_done_c7", done, 1'b1);
    checkOutput("basic_busy_c7", busy, 1'b1);
    checkOutput("basic_en_c7", mac_en, 1'b0);
    checkOutput("basic_cnt_c7", cnt_q, 16'h0106);
    applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, 1'b0);
    checkOutput("basic_done_c8", done, 1'b0);
    checkOutput("basic_busy_c8", busy, 1'b0);
    checkOutput("basic_cnt_final", cnt_q, 16'h0106);
  endtask

  initial begin
    bit         stlTab[8];
    logic [15:0] wTab[8];
    bit         enTab[8];
    logic [15:0] wrapTab[4];
    logic [15:0] dupTab[4];
    logic [7:0]  dupN[4];
    int         enCount;

    stlTab  = '{0, 1, 0, 0, 1, 0, 0, 0};
    wTab    = '{16'h0100, 16'h0101, 16'h0101, 16'h0102, 16'h0103, 16'h0103, 16'h0104, 16'h0105};
    enTab   = '{1, 0, 1, 1, 0, 1, 1, 1};
    wrapTab = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    dupTab  = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
    dupN    = '{0, 0, 1, 1};

    rst_n = 1'b0; start = 1'b0; n_in = '0; n_out = '0; base_w = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_xidx", x_idx, 8'd0);
    checkOutput("rst_nidx", n_idx, 8'd0);
    checkOutput("rst_cnt_d", cnt_d, 16'h0000);
    checkOutput("rst_cnt_q", cnt_q, 16'h0000);
    checkOutput("rst_mac_en", mac_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic pass");
    runBasicPass();

    $display("[TB] stalled pass");
    applyStimulus(1'b1, 8'd3, 8'd2, 16'h0100, 1'b0);
    enCount = 0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, stlTab[k-1]);
      checkOutput($sformatf("stall_waddr_c%0d", k), w_addr, wTab[k-1]);
      checkOutput($sformatf("stall_en_c%0d", k), mac_en, enTab[k-1]);
      if (stlTab[k-1]) begin
        checkOutput($sformatf("stall_clr_c%0d", k), mac_clr, 1'b0);
        checkOutput($sformatf("stall_last_c%0d", k), acc_last, 1'b0);
        checkOutput($sformatf("stall_hold_c%0d", k), cnt_d, wTab[k-1]);
      end
      if (mac_en) enCount++;
    end
    applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, 1'b0);
    checkOutput("stall_done_c9", done, 1'b1);
    checkOutput("stall_en_total", enCount, 6);
    applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, 1'b0);
    checkOutput("stall_cnt_final", cnt_q, 16'h0106);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 8'd4, 8'd1, 16'hFFFE, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 8'd4, 8'd1, 16'hFFFE, 1'b0);
      checkOutput($sformatf("wrap_waddr_c%0d", k), w_addr, wrapTab[k-1]);
      checkOutput($sformatf("wrap_last_c%0d", k), acc_last, (k == 4) ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b0, 8'd4, 8'd1, 16'hFFFE, 1'b0);
    checkOutput("wrap_done", done, 1'b1);
    checkOutput("wrap_cnt_final", cnt_q, 16'h0002);

    $display("[TB] rejected starts");
    applyStimulus(1'b1, 8'd0, 8'd2, 16'h5555, 1'b0);
    checkOutput("rej0_cnt_d_hold", cnt_d, 16'h0002);
    applyStimulus(1'b0, 8'd0, 8'd2, 16'h5555, 1'b0);
    checkOutput("rej0_err", err, 1'b1);
    checkOutput("rej0_busy", busy, 1'b0);
    checkOutput("rej0_cnt_q", cnt_q, 16'h0002);
    applyStimulus(1'b0, 8'd0, 8'd2, 16'h5555, 1'b0);
    checkOutput("rej0_err_clear", err, 1'b0);
    applyStimulus(1'b1, 8'd3, 8'd0, 16'h6666, 1'b0);
    applyStimulus(1'b0, 8'd3, 8'd0, 16'h6666, 1'b0);
    checkOutput("rej1_err", err, 1'b1);
    checkOutput("rej1_busy", busy, 1'b0);
    checkOutput("rej1_cnt_q", cnt_q, 16'h0002);

    $display("[TB] start ignored while busy");
    applyStimulus(1'b1, 8'd2, 8'd2, 16'h0200, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus((k == 2) ? 1'b1 : 1'b0, (k == 2) ? 8'd5 : 8'd2, 8'd2,
                    (k == 2) ? 16'h0900 : 16'h0200, 1'b0);
      checkOutput($sformatf("dup_waddr_c%0d", k), w_addr, dupTab[k-1]);
      checkOutput($sformatf("dup_nidx_c%0d", k), n_idx, dupN[k-1]);
      checkOutput($sformatf("dup_cnt_d_c%0d", k), cnt_d, dupTab[k-1] + 16'h0001);
    end
    applyStimulus(1'b1, 8'd5, 8'd5, 16'h0900, 1'b0);
    checkOutput("dup_done", done, 1'b1);
    checkOutput("dup_done_cnt_d", cnt_d, 16'h0204);
    applyStimulus(1'b0, 8'd2, 8'd2, 16'h0200, 1'b0);
    checkOutput("dup_idle_busy", busy, 1'b0);
    checkOutput("dup_cnt_final", cnt_q, 16'h0204);

    $display("[TB] single-input neurons");
    applyStimulus(1'b1, 8'd1, 8'd3, 16'h0010, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 8'd1, 8'd3, 16'h0010, 1'b0);
      checkOutput($sformatf("single_clr_c%0d", k), mac_clr, 1'b1);
      checkOutput($sformatf("single_last_c%0d", k), acc_last, 1'b1);
      checkOutput($sformatf("single_nidx_c%0d", k), n_idx, 8'(k - 1));
    end
    applyStimulus(1'b0, 8'd1, 8'd3, 16'h0010, 1'b0);
    checkOutput("single_done", done, 1'b1);

    $display("[TB] reset mid-pass");
    applyStimulus(1'b0, 8'd1, 8'd3, 16'h0010, 1'b0);
    applyStimulus(1'b1, 8'd3, 8'd2, 16'h0100, 1'b0);
    applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, 1'b0);
    applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, 1'b0);
    applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, 1'b0);
    checkOutput("abort_waddr_c3", w_addr, 16'h0102);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_cnt_d", cnt_d, 16'h0000);
    checkOutput("abort_mac_en", mac_en, 1'b0);
    checkOutput("abort_xidx", x_idx, 8'd0);
    @(posedge clk);
    #1;
    checkOutput("abort_waddr_cleared", w_addr, 16'h0000);
    checkOutput("abort_done_rst", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'd3, 8'd2, 16'h0100, 1'b0);
      checkOutput($sformatf("abort_no_done_%0d", k), done, 1'b0);
      checkOutput($sformatf("abort_idle_%0d", k), busy, 1'b0);
    end
    runBasicPass();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
